// File: rtl/oric_bus_rdmux_if.sv
// rtl/oric_bus_rdmux_if.sv - CPU read-data / ROM-bank bus bundle for oric_bus_rdmux
interface oric_bus_rdmux_if #(
    parameter int NUM_ROM = 2,
    parameter int BANK_W  = $clog2(NUM_ROM)
);
    logic                   phi2;
    logic                   cpu_rw;
    logic                   csio_n;
    logic                   csrom_n;
    logic                   csram_n;
    logic                   latch_sram;
    logic                   map_n;
    logic                   romdis_n;
    logic                   iocontrol_n;
    logic                   ece_n;
    logic [7:0]             exp_do;
    logic [7:0]             via_do;
    logic [8*NUM_ROM-1:0]   rom_do;
    logic [7:0]             md_rom_do;
    logic [7:0]             sram_do;
    logic [BANK_W-1:0]      rom_sel;
    logic                   rom_sel_req;
    logic [7:0]             cpu_di;
    logic [BANK_W-1:0]      rom_bank;
    logic [2:0]             src;
    logic                   bank_pending;
    logic                   bank_err;

    modport master (
        output phi2, cpu_rw, csio_n, csrom_n, csram_n, latch_sram, map_n, romdis_n,
               iocontrol_n, ece_n, exp_do, via_do, rom_do, md_rom_do, sram_do,
               rom_sel, rom_sel_req,
        input  cpu_di, rom_bank, src, bank_pending, bank_err
    );

    modport slave (
        input  phi2, cpu_rw, csio_n, csrom_n, csram_n, latch_sram, map_n, romdis_n,
               iocontrol_n, ece_n, exp_do, via_do, rom_do, md_rom_do, sram_do,
               rom_sel, rom_sel_req,
        output cpu_di, rom_bank, src, bank_pending, bank_err
    );
endinterface

// File: rtl/oric_bus_rdmux.sv
// rtl/oric_bus_rdmux.sv - prioritised 6502 read-data capture with PHI2-fall ROM bank switch
module oric_bus_rdmux #(
    parameter int NUM_ROM       = 2,
    parameter int BANK_W        = $clog2(NUM_ROM),
    parameter int RESET_BANK    = 0,
    parameter int SETTLE        = 0,
    parameter bit OPEN_BUS_HOLD = 1'b1
) (
    input  logic            CLK_IN,
    input  logic            RESETn,
    oric_bus_rdmux_if.slave bus
);
    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    logic              phi2_q, phi2_d;
    logic [3:0]        ph_cnt_q, ph_cnt_d;
    logic [7:0]        cpu_di_q, cpu_di_d;
    logic [2:0]        src_q, src_d;
    logic [BANK_W-1:0] rom_bank_q, rom_bank_d;
    logic [BANK_W-1:0] pend_bank_q, pend_bank_d;
    logic              bank_pending_q, bank_pending_d;
    logic              bank_err_q, bank_err_d;

    logic              phi2_fall;
    logic              cap_en;
    logic              req_ok;
    logic [7:0]        rom_rd;

    always_ff @(posedge CLK_IN or negedge RESETn) begin
        if (!RESETn) begin
            phi2_q         <= 1'b0;
            ph_cnt_q       <= 4'd0;
            cpu_di_q       <= 8'hFF;
            src_q          <= 3'd0;
            rom_bank_q     <= BANK_W'(RESET_BANK);
            pend_bank_q    <= BANK_W'(RESET_BANK);
            bank_pending_q <= 1'b0;
            bank_err_q     <= 1'b0;
        end else begin
            phi2_q         <= phi2_d;
            ph_cnt_q       <= ph_cnt_d;
            cpu_di_q       <= cpu_di_d;
            src_q          <= src_d;
            rom_bank_q     <= rom_bank_d;
            pend_bank_q    <= pend_bank_d;
            bank_pending_q <= bank_pending_d;
            bank_err_q     <= bank_err_d;
        end
    end

    always_comb begin
        phi2_d         = bus.phi2;
        ph_cnt_d       = ph_cnt_q;
        cpu_di_d       = cpu_di_q;
        src_d          = src_q;
        rom_bank_d     = rom_bank_q;
        pend_bank_d    = pend_bank_q;
        bank_pending_d = bank_pending_q;
        bank_err_d     = 1'b0;

        phi2_fall = phi2_q & ~bus.phi2;
        cap_en    = bus.phi2 & bus.cpu_rw & (ph_cnt_q == SETTLE_C);
        req_ok    = 32'(bus.rom_sel) < 32'(NUM_ROM);

        rom_rd = 8'h00;
        for (int k = 0; k < NUM_ROM; k++) begin
            if (rom_bank_q == BANK_W'(k)) rom_rd = bus.rom_do[8*k +: 8];
        end

        // Settle counter gives synchronous ROMs time before the read is sampled.
        if (!bus.phi2)                ph_cnt_d = 4'd0;
        else if (ph_cnt_q < SETTLE_C) ph_cnt_d = ph_cnt_q + 4'd1;

        if (cap_en) begin
            if (!bus.csio_n && !bus.iocontrol_n) begin
                cpu_di_d = bus.exp_do;    src_d = 3'd1;
            end else if (!bus.csio_n && bus.iocontrol_n) begin
                cpu_di_d = bus.via_do;    src_d = 3'd2;
            end else if (bus.csio_n && !bus.csrom_n && bus.map_n && bus.romdis_n) begin
                cpu_di_d = rom_rd;        src_d = 3'd3;
            end else if (!bus.ece_n && !bus.romdis_n && bus.map_n) begin
                cpu_di_d = bus.md_rom_do; src_d = 3'd4;
            end else if (!bus.csram_n && !bus.latch_sram) begin
                cpu_di_d = bus.sram_do;   src_d = 3'd5;
            end else begin
                src_d = 3'd0;
                if (!OPEN_BUS_HOLD) cpu_di_d = 8'hFF;
            end
        end

        // Fall applies the old pending bank first; a coincident request then re-arms.
        if (phi2_fall && bank_pending_q) begin
            rom_bank_d     = pend_bank_q;
            bank_pending_d = 1'b0;
        end
        if (bus.rom_sel_req) begin
            if (req_ok) begin
                pend_bank_d    = bus.rom_sel;
                bank_pending_d = 1'b1;
            end else begin
                bank_err_d = 1'b1;
            end
        end
    end

    assign bus.cpu_di       = cpu_di_q;
    assign bus.src          = src_q;
    assign bus.rom_bank     = rom_bank_q;
    assign bus.bank_pending = bank_pending_q;
    assign bus.bank_err     = bank_err_q;
endmodule

// File: tb/tb_oric_bus_rdmux.sv
// tb/tb_oric_bus_rdmux.sv - directed checks of oric_bus_rdmux in two parameter sets
module tb_oric_bus_rdmux;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        phi2 = 0, cpu_rw = 1, csio_n = 1, csrom_n = 1, csram_n = 1, latch_sram = 0;
    logic        map_n = 1, romdis_n = 1, iocontrol_n = 1, ece_n = 1;
    logic [7:0]  exp_do = 8'h00, via_do = 8'h00, md_rom_do = 8'h00, sram_do = 8'h00;
    logic [31:0] rom_do = 32'hA3A2_A1A0;
    logic [2:0]  rom_sel = 3'd0;
    logic        rom_sel_req = 1'b0;
    int          nvec = 0;
    int          nerr = 0;

    always #5 clk = ~clk;

    oric_bus_rdmux_if #(.NUM_ROM(4), .BANK_W(3)) bus0 ();
    oric_bus_rdmux_if #(.NUM_ROM(4), .BANK_W(3)) bus1 ();

    assign bus0.phi2 = phi2;               assign bus1.phi2 = phi2;
    assign bus0.cpu_rw = cpu_rw;           assign bus1.cpu_rw = cpu_rw;
    assign bus0.csio_n = csio_n;           assign bus1.csio_n = csio_n;
    assign bus0.csrom_n = csrom_n;         assign bus1.csrom_n = csrom_n;
    assign bus0.csram_n = csram_n;         assign bus1.csram_n = csram_n;
    assign bus0.latch_sram = latch_sram;   assign bus1.latch_sram = latch_sram;
    assign bus0.map_n = map_n;             assign bus1.map_n = map_n;
    assign bus0.romdis_n = romdis_n;       assign bus1.romdis_n = romdis_n;
    assign bus0.iocontrol_n = iocontrol_n; assign bus1.iocontrol_n = iocontrol_n;
    assign bus0.ece_n = ece_n;             assign bus1.ece_n = ece_n;
    assign bus0.exp_do = exp_do;           assign bus1.exp_do = exp_do;
    assign bus0.via_do = via_do;           assign bus1.via_do = via_do;
    assign bus0.rom_do = rom_do;           assign bus1.rom_do = rom_do;
    assign bus0.md_rom_do = md_rom_do;     assign bus1.md_rom_do = md_rom_do;
    assign bus0.sram_do = sram_do;         assign bus1.sram_do = sram_do;
    assign bus0.rom_sel = rom_sel;         assign bus1.rom_sel = rom_sel;
    assign bus0.rom_sel_req = rom_sel_req; assign bus1.rom_sel_req = rom_sel_req;

    oric_bus_rdmux #(.NUM_ROM(4), .BANK_W(3), .RESET_BANK(0), .SETTLE(0), .OPEN_BUS_HOLD(1'b1))
        u0 (.CLK_IN(clk), .RESETn(rst_n), .bus(bus0));
    oric_bus_rdmux #(.NUM_ROM(4), .BANK_W(3), .RESET_BANK(1), .SETTLE(3), .OPEN_BUS_HOLD(1'b0))
        u1 (.CLK_IN(clk), .RESETn(rst_n), .bus(bus1));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_cpu_di", bus0.cpu_di, 8'hFF);
        chk("rst_src", 8'(bus0.src), 8'd0);
        chk("rst_bank0", 8'(bus0.rom_bank), 8'd0);
        chk("rst_bank1", 8'(bus1.rom_bank), 8'd1);
        chk("rst_pend", 8'(bus0.bank_pending), 8'd0);
        chk("rst_err", 8'(bus0.bank_err), 8'd0);
        rst_n = 1'b1;

        // SRAM read, then masked by video latch
        csram_n = 0; sram_do = 8'h5A; phi2 = 1; tick();
        chk("sram_di", bus0.cpu_di, 8'h5A);
        chk("sram_src", 8'(bus0.src), 8'd5);
        phi2 = 0; tick();
        latch_sram = 1; phi2 = 1; tick();
        chk("latch_hold_di", bus0.cpu_di, 8'h5A);
        chk("latch_src", 8'(bus0.src), 8'd0);
        phi2 = 0; latch_sram = 0; csram_n = 1; tick();

        // Expansion vs VIA
        csio_n = 0; iocontrol_n = 0; exp_do = 8'h11; via_do = 8'h22; phi2 = 1; tick();
        chk("exp_di", bus0.cpu_di, 8'h11);
        chk("exp_src", 8'(bus0.src), 8'd1);
        iocontrol_n = 1; tick();
        chk("via_di", bus0.cpu_di, 8'h22);
        chk("via_src", 8'(bus0.src), 8'd2);
        phi2 = 0; csio_n = 1; tick();

        // Bank switch deferred to PHI2 fall
        csrom_n = 0; phi2 = 1; tick();
        chk("rom_b0_di", bus0.cpu_di, 8'hA0);
        chk("rom_src", 8'(bus0.src), 8'd3);
        rom_sel = 3'd2; rom_sel_req = 1; tick();
        rom_sel_req = 0;
        chk("req_pend", 8'(bus0.bank_pending), 8'd1);
        chk("req_bank_hold", 8'(bus0.rom_bank), 8'd0);
        tick();
        chk("high_bank_hold", 8'(bus0.rom_bank), 8'd0);
        chk("high_rom_di", bus0.cpu_di, 8'hA0);
        phi2 = 0; tick();
        chk("fall_bank", 8'(bus0.rom_bank), 8'd2);
        chk("fall_pend", 8'(bus0.bank_pending), 8'd0);
        phi2 = 1; tick();
        chk("rom_b2_di", bus0.cpu_di, 8'hA2);

        // Out-of-range request
        rom_sel = 3'd5; rom_sel_req = 1; tick();
        rom_sel_req = 0;
        chk("err_pulse", 8'(bus0.bank_err), 8'd1);
        chk("err_pend", 8'(bus0.bank_pending), 8'd0);
        tick();
        chk("err_clear", 8'(bus0.bank_err), 8'd0);
        chk("err_bank", 8'(bus0.rom_bank), 8'd2);

        // Request coincident with PHI2 fall
        rom_sel = 3'd3; rom_sel_req = 1; tick();
        phi2 = 0; rom_sel = 3'd1; tick();
        rom_sel_req = 0;
        chk("coinc_bank", 8'(bus0.rom_bank), 8'd3);
        chk("coinc_pend", 8'(bus0.bank_pending), 8'd1);
        phi2 = 1; tick();
        chk("rom_b3_di", bus0.cpu_di, 8'hA3);
        phi2 = 0; tick();
        chk("coinc_bank2", 8'(bus0.rom_bank), 8'd1);
        chk("coinc_pend2", 8'(bus0.bank_pending), 8'd0);
        csrom_n = 1;

        // Settle delay on u1 (SETTLE=3) from a clean reset
        rst_n = 0; tick(); rst_n = 1;
        csram_n = 0; sram_do = 8'h01; phi2 = 1; tick();
        chk("settle_c1", bus1.cpu_di, 8'hFF);
        sram_do = 8'h02; tick();
        chk("settle_c2", bus1.cpu_di, 8'hFF);
        sram_do = 8'h03; tick();
        chk("settle_c3", bus1.cpu_di, 8'hFF);
        chk("nosettle_c3", bus0.cpu_di, 8'h03);
        sram_do = 8'h04; tick();
        chk("settle_c4", bus1.cpu_di, 8'h04);
        chk("settle_src", 8'(bus1.src), 8'd5);

        // Open bus: u1 drives FF, u0 holds
        csram_n = 1; tick();
        chk("openbus_ff", bus1.cpu_di, 8'hFF);
        chk("openbus_src", 8'(bus1.src), 8'd0);
        chk("openbus_hold", bus0.cpu_di, 8'h04);

        // Async reset mid-PHI2 with pending request
        csrom_n = 0; rom_sel = 3'd2; rom_sel_req = 1; tick();
        rom_sel_req = 0;
        chk("pre_rst_pend", 8'(bus0.bank_pending), 8'd1);
        rst_n = 0; #1;
        chk("arst_di", bus0.cpu_di, 8'hFF);
        chk("arst_bank0", 8'(bus0.rom_bank), 8'd0);
        chk("arst_bank1", 8'(bus1.rom_bank), 8'd1);
        chk("arst_pend", 8'(bus0.bank_pending), 8'd0);
        tick(); rst_n = 1;
        phi2 = 0; tick(); phi2 = 1; tick(); phi2 = 0; tick();
        chk("discard_bank", 8'(bus0.rom_bank), 8'd0);
        chk("discard_pend", 8'(bus0.bank_pending), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
